sparsa_tile_sched: RTL

//  Sequencer for one row of sparse PEs. Loads one mask per PE, then streams paired up/left index+data beats into the row edge.

---
 rtl/sparsa_tile_sched.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/sparsa_tile_sched.sv
// Row sequencer for a line of sparse PEs: per-PE mask load, joint up/left beat streaming,
// MAC drain wait, finish strobe and a held result-valid handshake.
module sparsa_tile_sched #(
  parameter int Data_Width   = 32,
  parameter int Mask_Width   = 32,
  parameter int Index_Width  = $clog2(Mask_Width),
  parameter int Num_PE       = 4,
  parameter int Len_Width    = 16,
  parameter int Drain_Cycles = 8,
  parameter int PAD_INDEX    = Mask_Width - 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [Len_Width-1:0]   len,
  output logic                   busy,
  output logic                   done,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [Mask_Width-1:0]  cfg_mask,
  output logic [Num_PE-1:0]      mask_conf,
  output logic [Mask_Width-1:0]  new_mask,
  input  logic                   up_valid,
  output logic                   up_ready,
  input  logic [Index_Width-1:0] up_index,
  input  logic [Data_Width-1:0]  up_data,
  input  logic                   le_valid,
  output logic                   le_ready,
  input  logic [Index_Width-1:0] le_index,
  input  logic [Data_Width-1:0]  le_data,
  output logic [Index_Width-1:0] index_o_up,
  output logic [Data_Width-1:0]  data_o_up,
  output logic [Index_Width-1:0] index_o_le,
  output logic [Data_Width-1:0]  data_o_le,
  output logic                   finish,
  output logic                   res_valid,
  input  logic                   res_ready
);

  localparam int PE_CW = (Num_PE > 1) ? $clog2(Num_PE) : 1;
  localparam int DCW   = $clog2(Drain_Cycles + 1);
  localparam logic [Index_Width-1:0] PAD_IDX  = Index_Width'(PAD_INDEX);
  localparam logic [Mask_Width-1:0]  PAD_MASK = ~(Mask_Width'(1) << PAD_INDEX);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CONF   = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_FIN    = 3'd4;
  localparam logic [2:0] S_RESULT = 3'd5;

  logic [2:0]             r_state;
  logic [2:0]             w_next;
  logic [Len_Width-1:0]   r_remain;
  logic [PE_CW-1:0]       r_pe_cnt;
  logic [DCW-1:0]         r_drain;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_finish;
  logic                   r_res_valid;
  logic [Num_PE-1:0]      r_mask_conf;
  logic [Mask_Width-1:0]  r_new_mask;
  logic [Index_Width-1:0] r_idx_up;
  logic [Index_Width-1:0] r_idx_le;
  logic [Data_Width-1:0]  r_dat_up;
  logic [Data_Width-1:0]  r_dat_le;
  logic                   w_cfg_fire;
  logic                   w_fire;

  assign w_cfg_fire = (r_state == S_CONF) && cfg_valid;
  // Both edges advance together so up/left beats never drift apart.
  assign w_fire     = (r_state == S_STREAM) && up_valid && le_valid;

  assign cfg_ready  = (r_state == S_CONF);
  assign up_ready   = w_fire;
  assign le_ready   = w_fire;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start && !r_done) w_next = S_CONF;
      S_CONF:   if (w_cfg_fire && (r_pe_cnt == PE_CW'(Num_PE - 1)))
                  w_next = (r_remain != '0) ? S_STREAM : S_DRAIN;
      S_STREAM: if (w_fire && (r_remain == Len_Width'(1))) w_next = S_DRAIN;
      S_DRAIN:  if (r_drain == DCW'(1)) w_next = S_FIN;
      S_FIN:    w_next = S_RESULT;
      S_RESULT: if (res_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_remain    <= '0;
      r_pe_cnt    <= '0;
      r_drain     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_finish    <= 1'b0;
      r_res_valid <= 1'b0;
      r_mask_conf <= '0;
      r_new_mask  <= '0;
      r_idx_up    <= PAD_IDX;
      r_idx_le    <= PAD_IDX;
      r_dat_up    <= '0;
      r_dat_le    <= '0;
    end else begin
      r_state     <= w_next;
      r_busy      <= (w_next != S_IDLE);
      r_done      <= (r_state == S_RESULT) && (w_next == S_IDLE);
      r_finish    <= (w_next == S_FIN);
      r_res_valid <= (w_next == S_RESULT);
      r_mask_conf <= w_cfg_fire ? (Num_PE'(1) << r_pe_cnt) : '0;

      if (w_cfg_fire) begin
        r_new_mask <= cfg_mask & PAD_MASK;
        r_pe_cnt   <= r_pe_cnt + PE_CW'(1);
      end

      if ((r_state == S_IDLE) && (w_next == S_CONF)) begin
        r_remain <= len;
        r_pe_cnt <= '0;
      end else if (w_fire) begin
        r_remain <= r_remain - Len_Width'(1);
      end

      if ((w_next == S_DRAIN) && (r_state != S_DRAIN))
        r_drain <= DCW'(Drain_Cycles);
      else if (r_state == S_DRAIN)
        r_drain <= r_drain - DCW'(1);

      r_idx_up <= w_fire ? up_index : PAD_IDX;
      r_idx_le <= w_fire ? le_index : PAD_IDX;
      r_dat_up <= w_fire ? up_data  : '0;
      r_dat_le <= w_fire ? le_data  : '0;
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign finish     = r_finish;
  assign res_valid  = r_res_valid;
  assign mask_conf  = r_mask_conf;
  assign new_mask   = r_new_mask;
  assign index_o_up = r_idx_up;
  assign index_o_le = r_idx_le;
  assign data_o_up  = r_dat_up;
  assign data_o_le  = r_dat_le;

endmodule
